cond_exec_sequencer: RTL and testbench

- Multi-cycle instruction control FSM for the CPU datapath.
- Accepts decoded instruction fields (opcode, S-bit, condition) through a valid/ready handshake.
- Holds the architectural NZCV flag register and evaluates the condition field against it.
- Drives the 16-bit datapath enable vector stage by stage, or skips the instruction when the condition fails.

---
 rtl/cpu_ctrl_pkg.sv | 51 +++++
 rtl/cond_exec_sequencer_if.sv | 18 +
 rtl/cond_eval.sv | 32 +++
 rtl/cond_exec_sequencer.sv | 173 +++++++++++++++++
 tb/tb_cond_exec_sequencer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the conditional-execution sequencer:
// states, opcodes, condition codes, enable and flag bit positions.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_HALT
  } state_e;

  localparam logic [3:0] OP_CMP    = 4'b1000;
  localparam logic [3:0] OP_LOAD   = 4'b1001;
  localparam logic [3:0] OP_STORE  = 4'b1010;
  localparam logic [3:0] OP_BRANCH = 4'b1011;
  localparam logic [3:0] OP_HALT   = 4'b1111;

  localparam logic [3:0] CC_AL = 4'b0000;
  localparam logic [3:0] CC_EQ = 4'b0001;
  localparam logic [3:0] CC_NE = 4'b0010;
  localparam logic [3:0] CC_GT = 4'b0011;
  localparam logic [3:0] CC_GE = 4'b0100;
  localparam logic [3:0] CC_LT = 4'b0101;
  localparam logic [3:0] CC_HI = 4'b0110;
  localparam logic [3:0] CC_LS = 4'b0111;

  localparam int EN_PC_INC   = 0;
  localparam int EN_IR_LOAD  = 1;
  localparam int EN_REG_READ = 2;
  localparam int EN_ALU      = 3;
  localparam int EN_SHIFT    = 4;
  localparam int EN_MEM_REQ  = 5;
  localparam int EN_MEM_WE   = 6;
  localparam int EN_REG_WR   = 7;
  localparam int EN_PC_LOAD  = 8;
  localparam int EN_FLAG_WR  = 9;

  localparam int FL_N = 3;
  localparam int FL_Z = 2;
  localparam int FL_C = 1;
  localparam int FL_V = 0;

  function automatic logic op_is_alu(
    input logic [3:0] op
  );
    return !op[3];
  endfunction

endpackage

// File: rtl/cond_exec_sequencer_if.sv
// Instruction-field handshake between decoder and sequencer.
interface cond_exec_sequencer_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] opcode;
  logic       sbit;
  logic [3:0] cond;

  modport master (
    output instr_valid, opcode, sbit, cond,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, opcode, sbit, cond,
    output instr_ready
  );
endinterface

// File: rtl/cond_eval.sv
// Combinational condition-code check against the NZCV flags.
module cond_eval
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);

  logic n, z, c, v;

  assign n = flags_i[FL_N];
  assign z = flags_i[FL_Z];
  assign c = flags_i[FL_C];
  assign v = flags_i[FL_V];

  always_comb begin
    pass_o = 1'b1;
    case (cond_i)
      CC_AL:   pass_o = 1'b1;
      CC_EQ:   pass_o = z;
      CC_NE:   pass_o = !z;
      CC_GT:   pass_o = !z && (n == v);
      CC_GE:   pass_o = (n == v);
      CC_LT:   pass_o = (n != v);
      CC_HI:   pass_o = c && !z;
      CC_LS:   pass_o = !c || z;
      default: pass_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_exec_sequencer.sv
// Multi-cycle instruction control FSM with NZCV flags and skip logic.
// Optional MEM watchdog: define COND_SEQ_MEM_TIMEOUT_EN.
module cond_exec_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int EN_W        = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  cond_exec_sequencer_if.slave  ins,
  input  logic [3:0]            alu_flags,
  input  logic                  shift_carry,
  input  logic                  mem_ack,
  output logic [EN_W-1:0]       en,
  output logic [3:0]            flags,
  output logic                  done,
  output logic                  skipped,
  output logic                  halted
);

  state_e     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [3:0] cond_q, cond_d;
  logic [3:0] flags_q, flags_d;
  logic       sbit_q, sbit_d;
  logic       pass, timeout;
  logic       is_alu, is_cmp, is_ld, is_st;
  logic       is_br, is_halt, is_nop;

  cond_eval u_cond (
    .cond_i  (cond_q),
    .flags_i (flags_q),
    .pass_o  (pass)
  );

  assign is_alu  = op_is_alu(op_q);
  assign is_cmp  = (op_q == OP_CMP);
  assign is_ld   = (op_q == OP_LOAD);
  assign is_st   = (op_q == OP_STORE);
  assign is_br   = (op_q == OP_BRANCH);
  assign is_halt = (op_q == OP_HALT);
  assign is_nop  = !(is_alu || is_cmp || is_ld ||
                     is_st || is_br || is_halt);

  assign ins.instr_ready = (state_q == S_IDLE);
  assign halted          = (state_q == S_HALT);
  assign flags           = flags_q;

`ifdef COND_SEQ_MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(MEM_TIMEOUT) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout = !mem_ack &&
                   (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  // Cleared on the way into MEM so each access gets a full window.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_EXECUTE)
      cnt_d = '0;
    else if (state_q == S_MEM && !mem_ack)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cond_q  <= '0;
      sbit_q  <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cond_q  <= cond_d;
      sbit_q  <= sbit_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cond_d  = cond_q;
    sbit_d  = sbit_q;
    flags_d = flags_q;
    en      = '0;
    done    = 1'b0;
    skipped = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ins.instr_valid) begin
          op_d    = ins.opcode;
          cond_d  = ins.cond;
          sbit_d  = ins.sbit;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        en[EN_PC_INC]   = 1'b1;
        en[EN_IR_LOAD]  = 1'b1;
        en[EN_REG_READ] = 1'b1;
        // Failed condition wins, so a skipped HALT never halts.
        priority case (1'b1)
          !pass: begin
            done    = 1'b1;
            skipped = 1'b1;
            state_d = S_IDLE;
          end
          is_halt: state_d = S_HALT;
          is_nop: begin
            done    = 1'b1;
            state_d = S_IDLE;
          end
          default: state_d = S_EXECUTE;
        endcase
      end
      S_EXECUTE: begin
        en[EN_ALU]   = 1'b1;
        en[EN_SHIFT] = is_alu || is_cmp;
        if (sbit_q || is_cmp) begin
          en[EN_FLAG_WR] = 1'b1;
          flags_d = {alu_flags[FL_N], alu_flags[FL_Z],
                     alu_flags[FL_C] | shift_carry,
                     alu_flags[FL_V]};
        end
        priority case (1'b1)
          is_ld || is_st: state_d = S_MEM;
          is_cmp: begin
            done    = 1'b1;
            state_d = S_IDLE;
          end
          default: state_d = S_WRITEBACK;
        endcase
      end
      S_MEM: begin
        en[EN_MEM_REQ] = 1'b1;
        en[EN_MEM_WE]  = is_st;
        if (mem_ack) begin
          if (is_ld) begin
            state_d = S_WRITEBACK;
          end else begin
            done    = 1'b1;
            state_d = S_IDLE;
          end
        end else if (timeout) begin
          done    = 1'b1;
          skipped = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WRITEBACK: begin
        done = 1'b1;
        if (is_br) en[EN_PC_LOAD] = 1'b1;
        else       en[EN_REG_WR]  = 1'b1;
        state_d = S_IDLE;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cond_exec_sequencer.sv
// Directed self-checking bench for cond_exec_sequencer.
module tb_cond_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  alu_flags;
  logic        shift_carry;
  logic        mem_ack;
  logic [15:0] en;
  logic [3:0]  flags;
  logic        done, skipped, halted;

  int n_chk = 0;
  int n_err = 0;

  cond_exec_sequencer_if ifc ();

  cond_exec_sequencer #(
    .EN_W        (16),
    .MEM_TIMEOUT (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ins         (ifc),
    .alu_flags   (alu_flags),
    .shift_carry (shift_carry),
    .mem_ack     (mem_ack),
    .en          (en),
    .flags       (flags),
    .done        (done),
    .skipped     (skipped),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(
    input logic [3:0] op,
    input logic       s,
    input logic [3:0] c
  );
    check("ready", 32'(ifc.instr_ready), 1);
    ifc.instr_valid = 1'b1;
    ifc.opcode      = op;
    ifc.sbit        = s;
    ifc.cond        = c;
    tick();
    ifc.instr_valid = 1'b0;
  endtask

  // CMP sets flags to f (shift_carry held low).
  task automatic set_flags(input logic [3:0] f);
    alu_flags = f;
    issue(4'b1000, 1'b0, 4'b0000);
    tick();
    tick();
    check("cmp_flags", 32'(flags), 32'(f));
  endtask

  typedef struct {
    logic [3:0] f;
    logic [3:0] c;
    logic       skip;
  } cvec_t;

  cvec_t cv[9] = '{
    '{4'b1000, 4'b0101, 1'b0},
    '{4'b1000, 4'b0100, 1'b1},
    '{4'b1000, 4'b0011, 1'b1},
    '{4'b0010, 4'b0110, 1'b0},
    '{4'b0010, 4'b0111, 1'b1},
    '{4'b0110, 4'b0110, 1'b1},
    '{4'b0110, 4'b0111, 1'b0},
    '{4'b0110, 4'b0010, 1'b1},
    '{4'b1001, 4'b0011, 1'b0}
  };

  initial begin
    rst             = 1'b1;
    alu_flags       = '0;
    shift_carry     = 1'b0;
    mem_ack         = 1'b0;
    ifc.instr_valid = 1'b0;
    ifc.opcode      = '0;
    ifc.sbit        = 1'b0;
    ifc.cond        = '0;
    tick();
    tick();
    check("rst_flags", 32'(flags), 0);
    check("rst_en", 32'(en), 0);
    check("rst_done", 32'(done), 0);
    check("rst_halt", 32'(halted), 0);
    rst = 1'b0;
    tick();

    // ADD with flag set; mem_ack noise ignored
    alu_flags = 4'b1000;
    mem_ack   = 1'b1;
    issue(4'b0000, 1'b1, 4'b0000);
    check("add_dec_en", 32'(en), 32'h0007);
    check("add_dec_done", 32'(done), 0);
    tick();
    check("add_ex_en", 32'(en), 32'h0218);
    check("add_ex_done", 32'(done), 0);
    tick();
    check("add_wb_en", 32'(en), 32'h0080);
    check("add_wb_done", 32'(done), 1);
    check("add_flags", 32'(flags), 32'h8);
    mem_ack = 1'b0;
    tick();
    check("add_idle_done", 32'(done), 0);

    // CMP then BRANCH EQ taken
    alu_flags = 4'b0100;
    issue(4'b1000, 1'b0, 4'b0000);
    check("cmp_dec_done", 32'(done), 0);
    tick();
    check("cmp_ex_en", 32'(en), 32'h0218);
    check("cmp_ex_done", 32'(done), 1);
    tick();
    check("cmp_flags", 32'(flags), 32'h4);
    issue(4'b1011, 1'b0, 4'b0001);
    check("br_dec_en", 32'(en), 32'h0007);
    check("br_dec_skip", 32'(skipped), 0);
    tick();
    check("br_ex_en", 32'(en), 32'h0008);
    tick();
    check("br_wb_en", 32'(en), 32'h0100);
    check("br_wb_done", 32'(done), 1);
    tick();

    // shift carry ORed into C
    alu_flags   = 4'b0000;
    shift_carry = 1'b1;
    issue(4'b0011, 1'b1, 4'b0000);
    tick();
    tick();
    tick();
    check("sc_flags", 32'(flags), 32'h2);
    shift_carry = 1'b0;

    // sbit=0 leaves flags alone
    alu_flags = 4'b1111;
    issue(4'b0001, 1'b0, 4'b0000);
    tick();
    check("nos_ex_en", 32'(en), 32'h0018);
    tick();
    tick();
    check("nos_flags", 32'(flags), 32'h2);

    // BRANCH EQ with Z=0 is skipped
    issue(4'b1011, 1'b0, 4'b0001);
    check("bsk_en", 32'(en), 32'h0007);
    check("bsk_done", 32'(done), 1);
    check("bsk_skip", 32'(skipped), 1);
    tick();
    check("bsk_idle_en", 32'(en), 0);
    check("bsk_ready", 32'(ifc.instr_ready), 1);

    // skipped HALT does not halt
    issue(4'b1111, 1'b0, 4'b0001);
    check("hsk_skip", 32'(skipped), 1);
    tick();
    check("hsk_halt", 32'(halted), 0);

    // LOAD, ack on 5th MEM cycle
    issue(4'b1001, 1'b0, 4'b0000);
    tick();
    check("ld_ex_en", 32'(en), 32'h0008);
    tick();
    for (int i = 0; i < 5; i++) begin
      mem_ack = (i == 4);
      check("ld_mem_en", 32'(en), 32'h0020);
      check("ld_mem_done", 32'(done), 0);
      tick();
    end
    mem_ack = 1'b0;
    check("ld_wb_en", 32'(en), 32'h0080);
    check("ld_wb_done", 32'(done), 1);
    tick();

    // STORE, ack on 3rd MEM cycle
    issue(4'b1010, 1'b0, 4'b0000);
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      mem_ack = (i == 2);
      #1;
      check("st_mem_en", 32'(en), 32'h0060);
      check("st_mem_done", 32'(done), 32'(i == 2));
      tick();
    end
    mem_ack = 1'b0;
    check("st_idle_en", 32'(en), 0);

    // condition table via CMP + NOP
    foreach (cv[k]) begin
      set_flags(cv[k].f);
      issue(4'b1100, 1'b0, cv[k].c);
      check("cc_done", 32'(done), 1);
      check("cc_skip", 32'(skipped), 32'(cv[k].skip));
      tick();
    end

`ifdef COND_SEQ_MEM_TIMEOUT_EN
    issue(4'b1001, 1'b0, 4'b0000);
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      check("to_en", 32'(en), 32'h0020);
      check("to_done", 32'(done), 32'(i == 7));
      check("to_skip", 32'(skipped), 32'(i == 7));
      tick();
    end
    check("to_idle_en", 32'(en), 0);
    check("to_ready", 32'(ifc.instr_ready), 1);
`endif

    // reset mid-EXECUTE
    set_flags(4'b0100);
    alu_flags = 4'b1111;
    issue(4'b0000, 1'b1, 4'b0000);
    tick();
    check("mr_ex_en", 32'(en), 32'h0218);
    rst = 1'b1;
    tick();
    check("mr_flags", 32'(flags), 0);
    check("mr_en", 32'(en), 0);
    check("mr_ready", 32'(ifc.instr_ready), 1);
    rst = 1'b0;
    tick();

    // HALT ignores further instructions until reset
    issue(4'b1111, 1'b0, 4'b0000);
    check("h_dec_en", 32'(en), 32'h0007);
    tick();
    ifc.instr_valid = 1'b1;
    ifc.opcode      = 4'b0000;
    for (int i = 0; i < 10; i++) tick();
    check("h_halted", 32'(halted), 1);
    check("h_ready", 32'(ifc.instr_ready), 0);
    check("h_en", 32'(en), 0);
    ifc.instr_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("h_rst_halt", 32'(halted), 0);
    check("h_rst_ready", 32'(ifc.instr_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
